axilite_regfile_slave: RTL and testbench
========================================

// Module: axilite_regfile_slave
// PURPOSE
//   AXI4-Lite slave (responder end of the axilite_int slave modport) exposing a bank of
//   C_NUM_REGS read/write 32-bit control registers to fabric logic. Sits behind the
//   interconnect; fabric logic reads register contents in parallel and sees one-cycle write strobes.
//   Supports independent write and read channels, WSTRB byte lanes and SLVERR decoding.
// PARAMETERS
//   C_AXI_DATA_WIDTH  32  data width; only 32 is supported (elaboration $error otherwise)
//   C_AXI_ADDR_WIDTH  8   byte address width; word index = ADDR[C_AXI_ADDR_WIDTH-1:2]
//   C_NUM_REGS        16  number of registers; must be <= 2**(C_AXI_ADDR_WIDTH-2)
// PORTS
//   AXI_ACLK     in   1                clock
//   AXI_ARESET   in   1                reset, synchronous, active-high
//   AXI_AWADDR/AWPROT/AWVALID in, AXI_AWREADY out     write address channel (AWPROT ignored)
//   AXI_WDATA/WSTRB/WVALID in, AXI_WREADY out         write data channel
//   AXI_BRESP out 2, AXI_BVALID out 1, AXI_BREADY in 1 write response channel
//   AXI_ARADDR/ARPROT/ARVALID in, AXI_ARREADY out     read address channel (ARPROT ignored)
//   AXI_RDATA out 32, AXI_RRESP out 2, AXI_RVALID out 1, AXI_RREADY in 1  read data channel
//   regs_o       out  C_NUM_REGS*32    flattened register contents, reg i at [32*i +: 32]
//   wr_pulse_o   out  C_NUM_REGS       one-cycle strobe, bit i set on the commit cycle of a write to reg i
// BEHAVIOUR
//   Clocking: one clock; reset is synchronous and active-high.
//   Reset: all registers 0; AWREADY=WREADY=ARREADY=0 during reset, 1 the cycle after reset deasserts;
//     BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse_o=0. Reset mid-transaction drops all pending state.
//   Write: AW and W accepted independently, in either order or in the same cycle; each is latched into a
//     one-entry holding register. AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
//   Commit: in the first cycle both are held, the write commits: byte lane b is updated iff WSTRB[b];
//     wr_pulse_o[idx] asserts in that same cycle. BVALID rises the next cycle; both holds clear at commit.
//   BVALID is held with a stable BRESP until BREADY; no new AW/W is accepted while BVALID=1.
//   Minimum write latency: AW+W handshake in cycle N -> commit N+1 -> BVALID N+2.
//   Read: ARREADY = !RVALID. On AR handshake in cycle N, RDATA/RRESP are registered and RVALID=1 in N+1,
//     held stable until RREADY. Back-to-back: the next AR is accepted the cycle after the R handshake.
//   Decode: idx >= C_NUM_REGS -> response SLVERR (2'b10), no register change, no wr_pulse, RDATA=0.
//     Otherwise OKAY (2'b00). ADDR[1:0] is ignored (unaligned addresses are treated as aligned).
//   Collision: a read sampled in the same cycle as a write commit to the same reg returns the pre-write value.
//   The read and write paths never stall each other.
// STRUCTURE
//   axilite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the function
//     strb_merge(old, new, strb) that returns the byte-merged word.
//   Sub-module axilite_wr_collector: the AW/W holding registers, READY generation and commit strobe.
//     The top module holds the register array, the decoder, the B channel FSM (IDLE/RESP) and the R channel FSM (IDLE/DATA).
// TESTING
//   1. Write 0xDEADBEEF to 0x04 with AW,W in the same cycle and BREADY=1 -> BVALID 2 cycles later, BRESP=0,
//      regs_o[63:32]=0xDEADBEEF, wr_pulse_o=16'h0002 for 1 cycle.
//   2. W arrives 3 cycles before AW, WSTRB=4'b0101, data 0x11223344 over 0 -> reg=0x00220044.
//   3. Read 0x40 (idx 16) -> RRESP=2'b10, RDATA=0; write 0x40 -> BRESP=2'b10, regs_o unchanged, no pulse.
//   4. Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 until the B handshake.
//      Same for RREADY=0 -> RDATA stable, ARREADY=0.
//   5. Read and write commit to 0x08 in the same cycle (old 0x1, new 0x2) -> RDATA=0x1; a later read -> 0x2.
//   6. Assert AXI_ARESET while BVALID=1 and RVALID=1 -> both 0 the next cycle, all registers 0.

Source files
------------

// File: rtl/axilite_pkg.sv
// axilite_pkg: AXI4-Lite response codes, channel FSM states and byte-lane merge helper
package axilite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic {B_IDLE, B_RESP} b_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    function automatic logic [31:0] strb_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        return m;
    endfunction
endpackage

// File: rtl/axilite_wr_collector.sv
// axilite_wr_collector: one-entry AW/W holding registers, READY generation and write commit strobe
module axilite_wr_collector #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] awaddr,
    input  logic          awvalid,
    output logic          awready,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          wvalid,
    output logic          wready,
    input  logic          bvalid,
    output logic          commit,
    output logic [AW-1:0] addr,
    output logic [31:0]   data,
    output logic [3:0]    strb
);
    logic aw_held, w_held;
    always_comb begin
        awready = !rst && !aw_held && !bvalid;
        wready  = !rst && !w_held && !bvalid;
        commit  = !rst && aw_held && w_held;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            addr    <= '0;
            data    <= '0;
            strb    <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                addr    <= awaddr;
            end
            if (wvalid && wready) begin
                w_held <= 1'b1;
                data   <= wdata;
                strb   <= wstrb;
            end
        end
    end
endmodule

// File: rtl/axilite_regfile_slave.sv
// axilite_regfile_slave: AXI4-Lite slave exposing C_NUM_REGS 32-bit control registers with write strobes
module axilite_regfile_slave
    import axilite_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int C_NUM_REGS       = 16
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_AWADDR,
    input  logic [2:0]                      AXI_AWPROT,
    input  logic                            AXI_AWVALID,
    output logic                            AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]     AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
    input  logic                            AXI_WVALID,
    output logic                            AXI_WREADY,
    output logic [1:0]                      AXI_BRESP,
    output logic                            AXI_BVALID,
    input  logic                            AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_ARADDR,
    input  logic [2:0]                      AXI_ARPROT,
    input  logic                            AXI_ARVALID,
    output logic                            AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]     AXI_RDATA,
    output logic [1:0]                      AXI_RRESP,
    output logic                            AXI_RVALID,
    input  logic                            AXI_RREADY,
    output logic [C_NUM_REGS*32-1:0]        regs_o,
    output logic [C_NUM_REGS-1:0]           wr_pulse_o
);
    localparam int IW = C_AXI_ADDR_WIDTH - 2;
    if (C_AXI_DATA_WIDTH != 32) begin : g_bad_dw
        $error("axilite_regfile_slave supports only C_AXI_DATA_WIDTH=32");
    end
    if (C_NUM_REGS > 2**IW) begin : g_bad_nregs
        $error("C_NUM_REGS exceeds the addressable word range");
    end
    logic                        commit, w_ok, r_ok, ar_hs;
    logic [C_AXI_ADDR_WIDTH-1:0] w_addr;
    logic [31:0]                 w_data, rd_word;
    logic [3:0]                  w_strb;
    logic [IW-1:0]               w_idx, r_idx;
    logic [31:0]                 regs [C_NUM_REGS];
    logic [1:0]                  bresp_q;
    b_state_t                    b_state, b_next;
    r_state_t                    r_state, r_next;
    logic                        unused_ok;
    assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, w_addr[1:0], AXI_ARADDR[1:0]};
    axilite_wr_collector #(.AW(C_AXI_ADDR_WIDTH)) u_wr (
        .clk(AXI_ACLK), .rst(AXI_ARESET),
        .awaddr(AXI_AWADDR), .awvalid(AXI_AWVALID), .awready(AXI_AWREADY),
        .wdata(AXI_WDATA), .wstrb(AXI_WSTRB), .wvalid(AXI_WVALID), .wready(AXI_WREADY),
        .bvalid(AXI_BVALID), .commit(commit), .addr(w_addr), .data(w_data), .strb(w_strb)
    );
    assign w_idx = w_addr[C_AXI_ADDR_WIDTH-1:2];
    assign r_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
    // Out-of-range indices match no register, so they read as 0 and never pulse
    always_comb begin
        w_ok       = 1'b0;
        r_ok       = 1'b0;
        rd_word    = '0;
        wr_pulse_o = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (w_idx == IW'(i)) begin
                w_ok          = 1'b1;
                wr_pulse_o[i] = commit;
            end
            if (r_idx == IW'(i)) begin
                r_ok    = 1'b1;
                rd_word = regs[i];
            end
        end
    end
    always_ff @(posedge AXI_ACLK) begin
        for (int i = 0; i < C_NUM_REGS; i++)
            if (AXI_ARESET) regs[i] <= '0;
            else if (wr_pulse_o[i]) regs[i] <= strb_merge(regs[i], w_data, w_strb);
    end
    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign regs_o[32*g +: 32] = regs[g];
    end
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            b_state <= B_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            b_state <= b_next;
            if (commit) bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end
    always_comb begin
        b_next     = b_state == B_IDLE ? (commit ? B_RESP : B_IDLE) : (AXI_BREADY ? B_IDLE : B_RESP);
        AXI_BVALID = b_state == B_RESP;
        AXI_BRESP  = bresp_q;
    end
    // Register reads sample pre-commit contents, so a same-cycle write is not visible yet
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            r_state   <= R_IDLE;
            AXI_RDATA <= '0;
            AXI_RRESP <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                AXI_RDATA <= rd_word;
                AXI_RRESP <= r_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
    always_comb begin
        AXI_ARREADY = !AXI_ARESET && r_state == R_IDLE;
        ar_hs       = AXI_ARVALID && AXI_ARREADY;
        r_next      = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (AXI_RREADY ? R_IDLE : R_DATA);
        AXI_RVALID  = r_state == R_DATA;
    end
endmodule

// File: tb/tb_axilite_regfile_slave.sv
// tb_axilite_regfile_slave: directed table-driven bench for the AXI4-Lite register file slave
module tb_axilite_regfile_slave;
    logic         clk = 1'b0, rst = 1'b1;
    logic [7:0]   awaddr = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] regs_o;
    logic [15:0]  wr_pulse;
    logic [31:0]  mdl [16];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    axilite_regfile_slave dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .AXI_AWADDR(awaddr), .AXI_AWPROT(awprot), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARPROT(arprot), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [15:0] pulse;
        logic [1:0]  resp;
        logic [31:0] val;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = mdl[i];
        return f;
    endfunction

    task automatic axi_write(input vec_t v);
        @(negedge clk);
        wvalid = 1'b1; wdata = v.data; wstrb = v.strb;
        if (v.lead == 0) begin awvalid = 1'b1; awaddr = v.addr; end
        #1 chk("wready", wready, 1);
        for (int k = 0; k < v.lead; k++) begin
            @(negedge clk);
            wvalid = 1'b0;
            #1 chk("wready_held", wready, 0);
        end
        if (v.lead > 0) begin awvalid = 1'b1; awaddr = v.addr; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1 chk("commit_pulse", wr_pulse, v.pulse);
        @(negedge clk);
        #1 chk("bvalid", bvalid, 1);
        chk("bresp", bresp, v.resp);
        chk("pulse_one_cycle", wr_pulse, 0);
        @(negedge clk);
        #1 chk("bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        @(negedge clk);
        arvalid = 1'b1; araddr = a;
        #1 chk("arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        #1 chk("rvalid", rvalid, 1);
        chk("rdata", rdata, exp_d);
        chk("rresp", rresp, exp_r);
        @(negedge clk);
        #1 chk("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h04, 32'hDEADBEEF, 4'hF, 0, 16'h0002, 2'b00, 32'hDEADBEEF};
        vecs[1] = '{8'h0C, 32'h11223344, 4'b0101, 3, 16'h0008, 2'b00, 32'h00220044};
        vecs[2] = '{8'h0D, 32'hAABBCCDD, 4'b1000, 0, 16'h0008, 2'b00, 32'hAA220044};
        vecs[3] = '{8'h3C, 32'h12345678, 4'hF, 1, 16'h8000, 2'b00, 32'h12345678};
        vecs[4] = '{8'h40, 32'hFFFFFFFF, 4'hF, 0, 16'h0000, 2'b10, 32'h0};
        vecs[5] = '{8'hFC, 32'h55555555, 4'hF, 2, 16'h0000, 2'b10, 32'h0};
        vecs[6] = '{8'h08, 32'h00000001, 4'hF, 0, 16'h0004, 2'b00, 32'h00000001};
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        @(negedge clk);
        #1 chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_regs", regs_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);
        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i]);
            if (vecs[i].resp == 2'b00) mdl[vecs[i].addr[5:2]] = vecs[i].val;
            chk("regs_model", regs_o, flat());
            axi_read(vecs[i].addr, vecs[i].val, vecs[i].resp);
        end
        // B backpressure
        bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h10; wdata = 32'h5; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, 0);
            chk("bp_awready", awready, 0);
            chk("bp_wready", wready, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        #1 chk("bp_bvalid_clear", bvalid, 0);
        chk("bp_awready_back", awready, 1);
        mdl[4] = 32'h5;
        chk("bp_regs", regs_o, flat());
        // R backpressure
        rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b1; araddr = 8'h10;
        @(negedge clk);
        arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk("rp_rvalid", rvalid, 1);
            chk("rp_rdata", rdata, 32'h5);
            chk("rp_arready", arready, 0);
        end
        rready = 1'b1;
        @(negedge clk);
        #1 chk("rp_rvalid_clear", rvalid, 0);
        chk("rp_arready_back", arready, 1);
        // read sampled in the commit cycle of a write to the same register
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h08; wdata = 32'h2; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 8'h08;
        #1 chk("coll_pulse", wr_pulse, 16'h0004);
        @(negedge clk);
        arvalid = 1'b0;
        #1 chk("coll_rdata_old", rdata, 32'h1);
        chk("coll_bvalid", bvalid, 1);
        mdl[2] = 32'h2;
        @(negedge clk);
        axi_read(8'h08, 32'h2, 2'b00);
        chk("coll_regs", regs_o, flat());
        // reset with both responses pending
        bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h14; wdata = 32'h7; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 8'h04;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        #1 chk("pre_rst_bvalid", bvalid, 1);
        chk("pre_rst_rvalid", rvalid, 1);
        chk("pre_rst_rdata", rdata, 32'hDEADBEEF);
        rst = 1'b1;
        #1 chk("in_rst_awready", awready, 0);
        @(negedge clk);
        #1 chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_regs", regs_o, 0);
        chk("mid_rst_pulse", wr_pulse, 0);
        rst = 1'b0; bready = 1'b1; rready = 1'b1;
        #1 chk("after_rst_awready", awready, 1);
        chk("after_rst_wready", wready, 1);
        chk("after_rst_arready", arready, 1);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        axi_read(8'h14, 32'h0, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
